// File: rtl/sram_controller.sv
// sram_controller: 32-bit load/store port onto a 16-bit SRAM.
// Each word is split into two halfword accesses of WAIT_CYCLES cycles.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, nxt;
  logic [3:0]  cnt;
  logic [16:0] word_q;
  logic [31:0] wd_q;
  logic [31:0] off;
  logic        last;
  logic        req;
  logic        unused_ok;

  assign off       = address - BASE_ADDR;
  assign unused_ok = ^{off[31:19], off[1:0]};
  assign last      = (cnt == LAST);
  assign req       = wr_en | rd_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      word_q    <= '0;
      wd_q      <= '0;
      read_data <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt == state && state != IDLE)
             ? cnt + 4'd1 : 4'd0;
      // request fields are frozen here until DONE
      if (state == IDLE && req) begin
        word_q <= off[18:2];
        wd_q   <= write_data;
      end
      if (state == RD_LO && last)
        read_data[15:0] <= sram_dq_in;
      if (state == RD_HI && last)
        read_data[31:16] <= sram_dq_in;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (wr_en)      nxt = WR_LO;
        else if (rd_en) nxt = RD_LO;
      end
      WR_LO:   if (last) nxt = WR_HI;
      WR_HI:   if (last) nxt = DONE;
      RD_LO:   if (last) nxt = RD_HI;
      RD_HI:   if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    unique case (state)
      IDLE: ready = ~req;
      DONE: ready = 1'b1;
      WR_LO, WR_HI: begin
        sram_ce_n   = 1'b0;
        sram_ub_n   = 1'b0;
        sram_lb_n   = 1'b0;
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_addr   = {word_q, state == WR_HI};
        sram_dq_out = (state == WR_HI)
                    ? wd_q[31:16] : wd_q[15:0];
      end
      RD_LO, RD_HI: begin
        sram_ce_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_addr = {word_q, state == RD_HI};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scoreboard bench with a behavioural SRAM.
// Expected bus beats and load results are queued at issue time.
module tb_sram_controller;

  localparam int W = 3;
  localparam logic [31:0] BASE = 32'd1024;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
    logic        w;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_ce_n, sram_we_n, sram_oe_n;
  logic        sram_ub_n, sram_lb_n;

  int pass = 0;
  int total = 0;
  logic [31:0] last_rd = '0;
  beat_t       q_beat[$];
  logic [31:0] q_rd[$];

  logic [15:0] mem [0:4095];
  logic [15:0] shadow [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_a = '0;
  logic [15:0] poke_d = '0;

  sram_controller #(
    .WAIT_CYCLES(W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[11:0]];

  always @(posedge clk)
    if (poke_en)
      mem[poke_a] <= poke_d;
    else if (sram_ce_n === 1'b0 && sram_we_n === 1'b0)
      mem[sram_addr[11:0]] <= sram_dq_out;

  task poke(input logic [11:0] a, input logic [15:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    shadow[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Called on a negedge; returns on the DONE negedge (+1).
  task do_txn(input logic we, input logic re,
              input logic [31:0] a, input logic [31:0] wd,
              input bit chg, input bit from_done);
    logic [31:0] off;
    logic [16:0] wrd;
    logic [17:0] sa0, sa1;
    logic [31:0] exp;
    beat_t b;
    int low, n;
    off = a - BASE;
    wrd = off[18:2];
    sa0 = {wrd, 1'b0};
    sa1 = {wrd, 1'b1};
    for (int h = 0; h < 2; h++)
      for (int c = 0; c < W; c++) begin
        b.a = (h == 0) ? sa0 : sa1;
        b.w = we;
        b.d = !we ? 16'h0 : (h == 0) ? wd[15:0] : wd[31:16];
        q_beat.push_back(b);
      end
    if (we) begin
      shadow[sa0[11:0]] = wd[15:0];
      shadow[sa1[11:0]] = wd[31:16];
    end else begin
      q_rd.push_back({shadow[sa1[11:0]], shadow[sa0[11:0]]});
    end
    wr_en = we;
    rd_en = re;
    address = a;
    write_data = wd;
    #1;
    if (from_done) begin
      total++;
      if (ready !== 1'b1 || sram_ce_n !== 1'b1)
        $display("FAIL done_ignore: ready=%b ce_n=%b want 1 1",
                 ready, sram_ce_n);
      else pass++;
      @(negedge clk);
      #1;
    end
    total++;
    if (ready !== 1'b0)
      $display("FAIL accept_ready: got %b want 0", ready);
    else pass++;
    low = 1;
    n = 0;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (chg) begin
      address = 32'h2000;
      write_data = ~wd;
    end
    while (n < 40) begin
      #1;
      if (ready === 1'b1) break;
      low++;
      n++;
      total++;
      if (q_beat.size() == 0) begin
        $display("FAIL extra_beat: addr=%h got access want none",
                 sram_addr);
      end else begin
        b = q_beat.pop_front();
        if (sram_addr !== b.a || sram_we_n !== ~b.w ||
            sram_oe_n !== b.w || sram_dq_oe !== b.w ||
            sram_ce_n !== 1'b0 || sram_ub_n !== 1'b0 ||
            sram_lb_n !== 1'b0 || (b.w && sram_dq_out !== b.d))
          $display("FAIL beat: got a=%h d=%h we_n=%b oe_n=%b ce_n=%b want a=%h d=%h w=%b",
                   sram_addr, sram_dq_out, sram_we_n, sram_oe_n,
                   sram_ce_n, b.a, b.d, b.w);
        else pass++;
      end
      @(negedge clk);
    end
    total++;
    if (n >= 40)
      $display("FAIL timeout: got no DONE after %0d cycles want %0d", n, 2 * W);
    else pass++;
    total++;
    if (low !== 2 * W + 1)
      $display("FAIL ready_low: got %0d want %0d", low, 2 * W + 1);
    else pass++;
    total++;
    if (q_beat.size() != 0) begin
      $display("FAIL beats_left: got %0d want 0", q_beat.size());
      q_beat.delete();
    end else pass++;
    total++;
    if ({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n,
         sram_dq_oe} !== 6'b111110)
      $display("FAIL done_strobes: got %b want 111110",
               {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n,
                sram_lb_n, sram_dq_oe});
    else pass++;
    if (!we) begin
      exp = (q_rd.size() != 0) ? q_rd.pop_front() : 32'hx;
      last_rd = exp;
    end
    total++;
    if (read_data !== last_rd)
      $display("FAIL read_data: got %h want %h", read_data, last_rd);
    else pass++;
  endtask

  task test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    poke(12'd2, 16'h5678);
    poke(12'd3, 16'h1234);
    poke(12'd6, 16'h1111);
    poke(12'd7, 16'h2222);
    #1;
    total++;
    if (ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", ready);
    else pass++;
    total++;
    if ({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}
        !== 5'b11111)
      $display("FAIL reset_strobes: got %b want 11111",
               {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n});
    else pass++;
    total++;
    if (read_data !== 32'h0 || sram_addr !== 18'h0 ||
        sram_dq_oe !== 1'b0)
      $display("FAIL reset_regs: got rd=%h a=%h oe=%b want 0 0 0",
               read_data, sram_addr, sram_dq_oe);
    else pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task test_write;
    do_txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task test_read;
    do_txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    do_txn(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task test_priority;
    do_txn(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0, 1'b0);
    @(negedge clk);
    do_txn(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task test_latch;
    do_txn(1'b1, 1'b0, 32'h1003, 32'hA5A55A5A, 1'b1, 1'b0);
    @(negedge clk);
    do_txn(1'b0, 1'b1, 32'h1000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task test_wrap;
    do_txn(1'b1, 1'b0, 32'h0, 32'h13579BDF, 1'b0, 1'b0);
    @(negedge clk);
    do_txn(1'b0, 1'b1, 32'h2, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task test_back_to_back;
    do_txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 1'b0);
    do_txn(1'b1, 1'b0, 32'd1040, 32'h0BADF00D, 1'b0, 1'b1);
    do_txn(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task test_reset_mid;
    address = 32'd1036;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        #1;
        total++;
        if (read_data[15:0] !== 16'h1111)
          $display("FAIL lo_capture: got %h want 1111", read_data[15:0]);
        else pass++;
      end
      if (k == 4) rst_n = 1'b0;
      @(negedge clk);
    end
    #1;
    total++;
    if (ready !== 1'b1 || read_data !== 32'h0)
      $display("FAIL mid_reset: got ready=%b rd=%h want 1 0",
               ready, read_data);
    else pass++;
    total++;
    if ({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n,
         sram_dq_oe} !== 6'b111110 || sram_addr !== 18'h0)
      $display("FAIL mid_strobes: got %b a=%h want 111110 0",
               {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n,
                sram_lb_n, sram_dq_oe}, sram_addr);
    else pass++;
    rst_n = 1'b1;
    last_rd = '0;
    @(negedge clk);
    do_txn(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_priority;
    test_latch;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
